// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MIPS32 MEM-stage load/store sequencer for a byte-wide data memory
//
// Takes one byte/half/word request per handshake and walks it out as
// big-endian byte accesses (most significant byte at the lowest address).
// Load data is sign- or zero-extended. Misaligned, out-of-range and
// illegal-size requests are rejected without touching the array.
//
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   req                  request strobe, sampled only while idle
//   wr, size, unsigned_ld request kind: store/load, 00 b / 01 h / 10 w, zero-extend
//   addr, wdata          byte address, right-justified store data
//   busy, done, err      not idle, one-cycle completion, request rejected
//   rdata                extended load result, held until the next done
//   mem_addr, mem_wdata  byte address and write byte to the array
//   mem_we, mem_re       byte write / read strobes
//   mem_rdata            byte from the array, combinational from mem_addr
module data_mem_ctrl #(
  parameter int          SIZE          = 32,
  parameter logic [31:0] SIZE_MEM      = 32'h7FF,
  parameter int          SIZE_WORD_MEM = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     wr,
  input  logic [1:0]               size,
  input  logic                     unsigned_ld,
  input  logic [SIZE-1:0]          addr,
  input  logic [SIZE-1:0]          wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [SIZE-1:0]          rdata,
  output logic [SIZE-1:0]          mem_addr,
  output logic [SIZE_WORD_MEM-1:0] mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [SIZE_WORD_MEM-1:0] mem_rdata
);

  localparam int W = SIZE_WORD_MEM;
  localparam logic [SIZE:0] MEM_LIMIT = (SIZE+1)'(SIZE_MEM);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q;
  logic [1:0]      k_q;
  logic [2:0]      nbytes_q;
  logic            wr_q;
  logic            uns_q;
  logic [SIZE-1:0] wdata_q;
  // Only the bytes below the newest one need storing; the newest arrives on mem_rdata.
  logic [SIZE-W-1:0] acc_q;
  logic            busy_q, done_q, err_q, mem_we_q, mem_re_q;
  logic [SIZE-1:0] rdata_q, mem_addr_q;
  logic [W-1:0]    mem_wdata_q;

  logic [2:0]      nbytes_d;
  logic [SIZE:0]   end_addr_d;
  logic            err_d;
  logic [SIZE-1:0] acc_d;
  logic [SIZE-1:0] load_ext_d;
  logic            last_d;
  logic [1:0]      k_d;
  logic [2:0]      idx_d;

  function automatic logic [W-1:0] byte_sel(input logic [SIZE-1:0] data, input logic [2:0] idx);
    return W'(data >> (32'(idx) * W));
  endfunction

  always_comb begin
    nbytes_d = 3'd1;
    case (size)
      2'b01:   nbytes_d = 3'd2;
      2'b10:   nbytes_d = 3'd4;
      default: nbytes_d = 3'd1;
    endcase
  end

  // One extra bit so a request near the top of the address space cannot wrap into range.
  assign end_addr_d = {1'b0, addr} + (SIZE+1)'(nbytes_d);
  assign err_d = (size == 2'b11)
              || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00)
              || (end_addr_d > MEM_LIMIT);

  assign acc_d  = {acc_q, mem_rdata};
  assign last_d = ({1'b0, k_q} == nbytes_q - 3'd1);
  assign k_d    = k_q + 2'd1;
  assign idx_d  = nbytes_q - 3'd1 - {1'b0, k_d};

  always_comb begin
    load_ext_d = acc_d;
    case (nbytes_q)
      3'd1:    load_ext_d = {{(SIZE-W){acc_d[W-1] & ~uns_q}}, acc_d[W-1:0]};
      3'd2:    load_ext_d = {{(SIZE-2*W){acc_d[2*W-1] & ~uns_q}}, acc_d[2*W-1:0]};
      default: load_ext_d = acc_d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      nbytes_q    <= '0;
      wr_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q     <= wr;
            uns_q    <= unsigned_ld;
            nbytes_q <= nbytes_d;
            wdata_q  <= wdata;
            acc_q    <= '0;
            k_q      <= '0;
            busy_q   <= 1'b1;
            if (err_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              // Outputs for byte 0 are set up here so the first access lands in the first ACCESS cycle.
              state_q     <= ACCESS;
              mem_addr_q  <= addr;
              mem_we_q    <= wr;
              mem_re_q    <= ~wr;
              mem_wdata_q <= wr ? byte_sel(wdata, nbytes_d - 3'd1) : '0;
            end
          end
        end
        ACCESS: begin
          if (!wr_q) acc_q <= acc_d[SIZE-W-1:0];
          if (last_d) begin
            state_q     <= DONE;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
            if (!wr_q) rdata_q <= load_ext_d;
          end else begin
            k_q        <= k_d;
            mem_addr_q <= mem_addr_q + SIZE'(1);
            if (wr_q) mem_wdata_q <= byte_sel(wdata_q, idx_d);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_we, mem_re;
  logic [31:0] rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  data_mem_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [0:2047];
  logic [7:0] ref_mem [0:2047];

  assign mem_rdata = mem[mem_addr[10:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic e; logic [31:0] r; int c; } res_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wexp_t;

  res_t        sb_q[$];
  wexp_t       exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] last_rdata = 32'h0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  res_t  mon_r;
  wexp_t mon_w;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we || mem_re || done) chk("busy_act", busy, 1);
      if (mem_we) begin
        chk("we_re_both", mem_re, 0);
        if (exp_wr_q.size() == 0) chk("we_unexp", mem_we, 0);
        else begin
          mon_w = exp_wr_q.pop_front();
          chk("we_addr", mem_addr, mon_w.a);
          chk("we_data", mem_wdata, mon_w.d);
        end
      end
      if (mem_re) begin
        if (exp_rd_q.size() == 0) chk("re_unexp", mem_re, 0);
        else chk("re_addr", mem_addr, exp_rd_q.pop_front());
      end
      if (done) begin
        if (sb_q.size() == 0) chk("done_unexp", done, 0);
        else begin
          mon_r = sb_q.pop_front();
          chk("done_cyc", cyc, mon_r.c);
          chk("err", err, mon_r.e);
          chk("rdata", rdata, mon_r.r);
        end
      end
    end
  end

  task automatic push_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
    int          n;
    logic        e;
    logic [32:0] end_a;
    logic [31:0] v, ak;
    wexp_t       x;
    res_t        r;
    n = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 1;
    end_a = {1'b0, a} + 33'(n);
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
        || (end_a > 33'h7FF);
    v = 32'h0;
    if (!e) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        if (w) begin
          x.a = ak;
          x.d = 8'(d >> (8 * (n - 1 - k)));
          ref_mem[ak[10:0]] = x.d;
          exp_wr_q.push_back(x);
        end else begin
          exp_rd_q.push_back(ak);
          v = {v[23:0], ref_mem[ak[10:0]]};
        end
      end
      if (!w) begin
        if (n == 1)      v = u ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (n == 2) v = u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        last_rdata = v;
      end
    end
    r.e = e;
    r.r = last_rdata;
    r.c = cyc + (e ? 1 : n + 1);
    sb_q.push_back(r);
    wr = w; size = sz; unsigned_ld = u; addr = a; wdata = d; req = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (sb_q.size() == 0) break;
      chk("busy_run", busy, 1);
    end
    if (sb_q.size() != 0) begin
      chk("timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    req = 1'b0;
    chk("idle_busy", busy, 0);
  endtask

  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    push_req(w, sz, u, a, d);
    wait_done();
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] ra;
    for (int i = 0; i < 2048; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_strobes", {mem_we, mem_re}, 0);
    reset = 1'b0;

    // store/load word
    send(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    send(0, 2'b10, 0, 32'h10, 32'h0);
    // byte and half sign/zero extension
    send(1, 2'b00, 0, 32'h21, 32'h00000080);
    send(0, 2'b00, 0, 32'h21, 32'h0);
    send(0, 2'b00, 1, 32'h21, 32'h0);
    send(1, 2'b01, 0, 32'h22, 32'h00008001);
    send(0, 2'b01, 0, 32'h22, 32'h0);
    send(0, 2'b01, 1, 32'h22, 32'h0);
    // rejected requests
    send(0, 2'b10, 0, 32'h12, 32'h0);
    send(0, 2'b01, 0, 32'h13, 32'h0);
    send(0, 2'b11, 0, 32'h0, 32'h0);
    send(1, 2'b01, 0, 32'h13, 32'hFFFF);
    // range boundary
    send(1, 2'b10, 0, 32'h7F8, 32'h12345678);
    send(0, 2'b10, 0, 32'h7F8, 32'h0);
    send(0, 2'b10, 0, 32'h7FC, 32'h0);
    send(1, 2'b10, 0, 32'h7FC, 32'hCAFEF00D);
    send(1, 2'b00, 0, 32'h7FE, 32'h9C);
    send(0, 2'b00, 0, 32'h7FE, 32'h0);
    send(0, 2'b00, 0, 32'hFFFFFFFF, 32'h0);

    // req held across two loads, inputs disturbed and req toggled mid-access
    push_req(0, 2'b10, 0, 32'h10, 32'h0);
    @(posedge clk); #2;
    addr = 32'h0BAD0001; size = 2'b11; wr = 1'b1; req = 1'b0;
    chk("hs_busy", busy, 1);
    @(posedge clk); #2;
    req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (sb_q.size() == 0) break;
      chk("hs_busy_run", busy, 1);
    end
    chk("hs_first_done", sb_q.size(), 0);
    chk("hs_idle", busy, 0);
    push_req(0, 2'b10, 0, 32'h7F8, 32'h0);
    wait_done();

    // random aligned traffic in the low region
    for (int i = 0; i < 12; i++) begin
      rsz = 2'($urandom_range(0, 2));
      ra  = 32'($urandom_range(0, 63));
      if (rsz == 2'b01) ra[0] = 1'b0;
      if (rsz == 2'b10) ra[1:0] = 2'b00;
      send(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    // reset during the second byte of a word store
    ref_mem[12'h040] = 8'hA1;
    exp_wr_q.push_back('{a: 32'h40, d: 8'hA1});
    wr = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h40; wdata = 32'hA1B2C3D4; req = 1'b1;
    @(posedge clk); #2;
    req = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_we", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("rst_we_async", mem_we, 0);
    chk("rst_busy_async", busy, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst2_outs", {busy, done, err, mem_we, mem_re}, 0);
    chk("rst2_rdata", rdata, 0);
    chk("rst2_addr", mem_addr, 0);
    chk("rst2_wdata", mem_wdata, 0);
    last_rdata = 32'h0;
    reset = 1'b0;
    chk("rst_mem", {mem[12'h040], mem[12'h041], mem[12'h042], mem[12'h043]}, 32'hA1000000);
    send(0, 2'b10, 0, 32'h40, 32'h0);

    chk("wr_q_empty", exp_wr_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    chk("sb_q_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Multi-cycle access sequencer between the MIPS32 MEM stage and the byte-wide data memory array.
- Accepts one load/store request per handshake (byte, halfword or word) and serializes it into big-endian byte accesses, MSB at the lowest address.
- Sign- or zero-extends load data.
- Flags misaligned, out-of-range and illegal-size requests without touching memory.

Parameters:
- SIZE, 32, data/address width.
- SIZE_MEM, 32'h7FF, number of bytes in the memory array; valid byte indices are 0..SIZE_MEM-1.
- SIZE_WORD_MEM, 8, memory word (byte lane) width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only when busy=0.
- wr  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_ld  in  1  1=zero-extend load (lbu/lhu), 0=sign-extend.
- addr  in  SIZE  byte address.
- wdata  in  SIZE  store data, right-justified.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1=request rejected.
- rdata  out  SIZE  extended load result; held until the next done.
- mem_addr  out  SIZE  byte address to the array.
- mem_wdata  out  SIZE_WORD_MEM  byte to write.
- mem_we  out  1  byte write strobe.
- mem_re  out  1  byte read strobe.
- mem_rdata  in  SIZE_WORD_MEM  byte read from the array; combinational from mem_addr.

Behaviour:
- Reset: asynchronous, active-high. Sets state=IDLE and all outputs to 0 (busy, done, err, rdata, mem_addr, mem_wdata, mem_we, mem_re), plus all internal latches.
- Reset mid-operation: the access aborts immediately and strobes drop without waiting for a clock. Bytes already written stay in memory. No done is produced.
- States: IDLE, ACCESS, DONE.
- IDLE -> ACCESS or DONE: when req=1 at a rising edge (cycle T), latch wr, size, unsigned_ld, addr, wdata.
- nbytes: 1, 2 or 4 for size 00, 01, 10.
- Error check, evaluated at acceptance:
  - size=11;
  - size=01 and addr[0]=1;
  - size=10 and addr[1:0]!=0;
  - addr+nbytes > SIZE_MEM, computed in SIZE+1 bits so wrap-around cannot mask it.
- On error: go straight to DONE. No mem_re/mem_we pulse. rdata is unchanged.
- ACCESS: byte counter k runs from 0 to nbytes-1, one byte per cycle.
  - mem_addr = latched addr + k.
  - Store: mem_we=1 and mem_wdata = byte (nbytes-1-k) of wdata, counting byte 0 as bits 7:0. MSB goes to the lowest address.
  - Load: mem_re=1; at each edge, acc = {acc[SIZE-9:0], mem_rdata}, with acc cleared at acceptance.
  - mem_we and mem_re are never high together, and never high outside ACCESS.
  - After the last byte: go to DONE.
- DONE, lasting one cycle:
  - done=1; err=1 if rejected, else 0.
  - Loads without error: rdata = acc extended from nbytes*8 bits, sign-extended unless unsigned_ld=1.
  - Stores: rdata is unchanged.
  - Next state is IDLE.
- Latency:
  - ACCESS occupies cycles T+1..T+nbytes; done is high in cycle T+nbytes+1.
  - Error case: done is high in cycle T+1.
- req while busy=1 (including DONE) is ignored, not queued. The requester holds req until it sees done.
- Back-to-back: with req held high, the next accept happens in the IDLE cycle right after DONE. Throughput is one request per nbytes+2 cycles.
- mem_addr and mem_wdata are don't-care outside ACCESS, but are driven to 0.

Test Plan:
- Store then load: sw wdata=32'hDEADBEEF at addr=0x10 -> 4 cycles of mem_we at 0x10..0x13 with bytes DE, AD, BE, EF; done at T+5, err=0. Then lw at 0x10 -> rdata=32'hDEADBEEF, done at T+5.
- Sign extension:
  - sb 8'h80 at 0x21, then lb -> rdata=32'hFFFFFF80; lbu -> 32'h00000080.
  - sh 16'h8001 at 0x22, then lh -> 32'hFFFF8001; lhu -> 32'h00008001; done at T+3.
- Misalignment: lw at 0x12, lh at 0x13, size=11 at 0x0 -> each gives done at T+1 with err=1, no mem_re/mem_we, rdata unchanged from the prior load.
- Range boundary with SIZE_MEM=0x7FF:
  - lw at 0x7F8 -> err=0.
  - lw at 0x7FC -> err=1.
  - lb at 0x7FE -> err=0.
  - lb at 0xFFFFFFFF -> err=1, with no wrap.
- Handshake: req held high across two lw requests -> second accept occurs the cycle after the first done. Toggling req during ACCESS has no effect; busy stays high from T+1 through DONE.
- Reset mid-operation: assert reset during the 2nd byte of an sw -> mem_we drops asynchronously, no done; memory holds only byte 0. After release, state is IDLE and all outputs are 0.
